// File: rtl/seq_detect_param.sv
// Serial pattern detector: matches a runtime-loadable PAT_W-bit pattern on a
// valid-qualified bit stream, with overlapping/non-overlapping restart.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             in_valid,
    input  logic             seq,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned      HIST_W   = PAT_W - 1;
    localparam int unsigned      FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  pat;
    logic [HIST_W-1:0] hist;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  cand;
    logic              hit;

    // Candidate window and match decision; a pattern load suppresses the match.
    always_comb begin
        cand = {hist, seq};
        hit  = 1'b0;
        if (in_valid && !pat_load && (fill == FILL_MAX) && (cand == pat)) begin
            hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            pat       <= PATTERN;
            hist      <= '0;
            fill      <= '0;
            out       <= 1'b0;
            match_cnt <= '0;
        end else begin
            if (pat_load) begin
                pat  <= pat_in;
                hist <= '0;
                fill <= '0;
                out  <= 1'b0;
            end else if (in_valid) begin
                out <= hit;
                if (hit && !overlap) begin
                    // Non-overlapping restart drops every bit used by the match.
                    hist <= '0;
                    fill <= '0;
                end else begin
                    hist <= cand[HIST_W-1:0];
                    if (fill != FILL_MAX) begin
                        fill <= fill + FILL_W'(1);
                    end
                end
            end else begin
                out <= 1'b0;
            end

            // Clear wins over a coincident match, which then goes uncounted.
            if (cnt_clr) begin
                match_cnt <= '0;
            end else if (hit && (match_cnt != CNT_MAX)) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: vector table on the default instance,
// hand-written saturation/clear sequence on a narrow-counter instance.
module tb_seq_detect_param;

    logic       clk;
    logic       arstn;
    logic       in_valid;
    logic       seq;
    logic       overlap;
    logic       pat_load;
    logic [3:0] pat_in;
    logic       cnt_clr;
    logic       out_a;
    logic [7:0] cnt_a;
    logic       out_b;
    logic [1:0] cnt_b;

    int n_checks;
    int n_fail;

    typedef struct packed {
        logic       arstn;
        logic       in_valid;
        logic       seq;
        logic       overlap;
        logic       pat_load;
        logic [3:0] pat_in;
        logic       cnt_clr;
        logic       exp_out;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[$];
    logic cur_ov;

    seq_detect_param dut (
        .clk(clk), .arstn(arstn), .in_valid(in_valid), .seq(seq),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .out(out_a), .match_cnt(cnt_a)
    );

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b1111), .CNT_W(2)) dut_sat (
        .clk(clk), .arstn(arstn), .in_valid(in_valid), .seq(seq),
        .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
        .cnt_clr(cnt_clr), .out(out_b), .match_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic void add_rst();
        vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0});
    endfunction

    function automatic void add_bit(input logic b, input logic eo, input int ec,
                                    input logic clr = 1'b0);
        vecs.push_back('{1'b1, 1'b1, b, cur_ov, 1'b0, 4'h0, clr, eo, 8'(ec)});
    endfunction

    function automatic void add_idle(input int ec);
        vecs.push_back('{1'b1, 1'b0, 1'b1, cur_ov, 1'b0, 4'h0, 1'b0, 1'b0, 8'(ec)});
    endfunction

    // Load row also presents a valid 1 bit, which must be ignored.
    function automatic void add_load(input logic [3:0] p, input int ec);
        vecs.push_back('{1'b1, 1'b1, 1'b1, cur_ov, 1'b1, p, 1'b0, 1'b0, 8'(ec)});
    endfunction

    task automatic drive_sat(input logic rst_v, input logic b, input logic clr);
        @(negedge clk);
        arstn    = rst_v;
        in_valid = 1'b1;
        seq      = b;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = 4'h0;
        cnt_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        arstn    = 1'b0;
        in_valid = 1'b0;
        seq      = 1'b0;
        overlap  = 1'b1;
        pat_load = 1'b0;
        pat_in   = 4'h0;
        cnt_clr  = 1'b0;

        // Overlapping, default 1101: pulses after bits 4, 9, 12.
        cur_ov = 1'b1;
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
        add_bit(0, 0, 1); add_bit(1, 0, 1); add_bit(1, 0, 1); add_bit(0, 0, 1);
        add_bit(1, 1, 2); add_bit(1, 0, 2); add_bit(0, 0, 2); add_bit(1, 1, 3);
        // Non-overlapping: bit 12 no longer matches.
        cur_ov = 1'b0;
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
        add_bit(0, 0, 1); add_bit(1, 0, 1); add_bit(1, 0, 1); add_bit(0, 0, 1);
        add_bit(1, 1, 2); add_bit(1, 0, 2); add_bit(0, 0, 2); add_bit(1, 0, 2);
        // Valid gap keeps the partial match.
        cur_ov = 1'b1;
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0);
        add_idle(0); add_idle(0); add_idle(0);
        add_bit(1, 1, 1); add_idle(1);
        // Mid-stream reset loses the partial match.
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0);
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 1);
        // Pattern load 1011, then reload 1101 keeping the count.
        add_rst();
        add_load(4'b1011, 0);
        add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 0, 0); add_bit(1, 1, 1);
        add_bit(0, 0, 1); add_bit(1, 0, 1); add_bit(1, 1, 2);
        add_load(4'b1101, 2);
        add_bit(1, 0, 2); add_bit(1, 0, 2); add_bit(0, 0, 2); add_bit(1, 1, 3);
        // Clear coincident with a match: pulse still fires, count goes to 0.
        add_rst();
        add_bit(1, 0, 0); add_bit(1, 0, 0); add_bit(0, 0, 0); add_bit(1, 1, 0, 1'b1);
        add_bit(1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            arstn    = vecs[i].arstn;
            in_valid = vecs[i].in_valid;
            seq      = vecs[i].seq;
            overlap  = vecs[i].overlap;
            pat_load = vecs[i].pat_load;
            pat_in   = vecs[i].pat_in;
            cnt_clr  = vecs[i].cnt_clr;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d out", i), int'(out_a), int'(vecs[i].exp_out));
            chk($sformatf("vec%0d match_cnt", i), int'(cnt_a), int'(vecs[i].exp_cnt));
        end

        // Saturation on a 2-bit counter with periodic pattern 1111.
        drive_sat(1'b0, 1'b0, 1'b0);
        chk("sat reset out", int'(out_b), 0);
        chk("sat reset cnt", int'(cnt_b), 0);
        for (int k = 1; k <= 7; k++) begin
            drive_sat(1'b1, 1'b1, 1'b0);
            chk($sformatf("sat bit%0d out", k), int'(out_b), (k >= 4) ? 1 : 0);
            chk($sformatf("sat bit%0d cnt", k), int'(cnt_b),
                (k < 4) ? 0 : ((k - 3) > 3 ? 3 : (k - 3)));
        end
        drive_sat(1'b1, 1'b1, 1'b1);
        chk("sat clr out", int'(out_b), 1);
        chk("sat clr cnt", int'(cnt_b), 0);
        drive_sat(1'b1, 1'b1, 1'b0);
        chk("sat after clr cnt", int'(cnt_b), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial-pattern detector, the next generation of our fixed 1101 Moore detectors. It takes a 1-bit serial stream qualified by a valid strobe and matches it against a runtime-loadable `PAT_W`-bit pattern. Matching can run in overlapping or non-overlapping mode. On each match it emits a registered one-cycle pulse and increments a saturating match counter. It sits directly on the serial input path, in place of the fixed-pattern detectors.

## Interface
- `PAT_W`, default 4: pattern length in bits, minimum 2.
- `PATTERN`, default 4'b1101: pattern value after reset. The MSB is the first bit received.
- `CNT_W`, default 8: width of the match counter.

- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `arstn`: input, 1 bit. Reset is synchronous and active-low. While it is low at a rising edge, all state goes to its reset value.
- `in_valid`: input, 1 bit. `seq` is sampled only on edges where this is 1.
- `seq`: input, 1 bit. Serial data bit.
- `overlap`: input, 1 bit. 1 selects overlapping mode, 0 selects non-overlapping mode.
- `pat_load`: input, 1 bit. Loads `pat_in` into the pattern register.
- `pat_in`: input, `PAT_W` bits. New pattern value.
- `cnt_clr`: input, 1 bit. Clears `match_cnt`.
- `out`: output, 1 bit. Registered match pulse.
- `match_cnt`: output, `CNT_W` bits. Saturating count of matches.

## Operation
- Internal state:
  - `pat` register, `PAT_W` bits; reset value `PATTERN`.
  - `hist` shift register, `PAT_W-1` bits, holding the most recent valid bits.
  - `fill` counter, 0 to `PAT_W-1`: the number of valid bits held in `hist` since the last restart, saturating at `PAT_W-1`.
- Reset values: `out`=0, `match_cnt`=0, `hist`=0, `fill`=0, `pat`=`PATTERN`.
- Priority at each edge, highest first: reset, then `pat_load`, then the valid-bit update.
- `pat_load`=1:
  - `pat` ← `pat_in`, `hist` ← 0, `fill` ← 0, `out` ← 0.
  - `seq` and `in_valid` are ignored on that edge.
  - `match_cnt` is unaffected, except that `cnt_clr` still applies.
- Valid-bit update (`in_valid`=1): form `cand = {hist, seq}`.
  - A match occurs when `fill == PAT_W-1` and `cand == pat`.
  - On a match with `overlap`=1: `hist` ← lower `PAT_W-1` bits of `cand`; `fill` stays at `PAT_W-1`.
  - On a match with `overlap`=0: `hist` ← 0 and `fill` ← 0, so the restart discards all bits used by the match.
  - On no match: `hist` ← lower `PAT_W-1` bits of `cand`; `fill` ← min(`fill`+1, `PAT_W-1`).
  - `out` ← 1 on a match, otherwise 0.
- `in_valid`=0: `hist` and `fill` hold; `out` ← 0. Gaps in the valid stream do not break a partial match.
- `overlap` is sampled on every valid edge. A change affects only the next match decision and never retroactively restarts the search.
- `match_cnt` update at each edge:
  - `cnt_clr`=1: `match_cnt` ← 0. This wins over a simultaneous match, and that match is not counted.
  - Otherwise, on a match: `match_cnt` ← `match_cnt`+1, saturating at 2^`CNT_W`−1 with no wrap.

## Timing
- Latency: `out` rises in the cycle after the edge that samples the final pattern bit, i.e. one edge of latency. It is high for exactly one cycle per match.
- Back-to-back matches are possible when overlap=1 and the pattern is periodic, e.g. `pat`=4'b1111. `out` then stays high across consecutive cycles, one cycle per match.
- `match_cnt` updates on the same edge as `out`.
- A `pat_load` takes effect on its own edge. The first match against the new pattern is possible no earlier than `PAT_W` valid edges later.
- Reset asserted mid-stream: the partial match is lost. The first possible match is `PAT_W` valid bits after `arstn` returns high.
- `pat` is not a sequence; it is fully general for any `PAT_W`. There is no fixed state encoding.

## Test plan
- Default pattern 1101, overlap=1, in_valid=1, stream 1,1,0,1,0,1,1,0,1,1,0,1 → `out` pulses after bits 4, 9 and 12; `match_cnt`=3.
- Same stream with overlap=0 → `out` pulses after bits 4 and 9 only; `match_cnt`=2.
- Stream 1,1,0 with in_valid=1, then 3 cycles of in_valid=0, then 1 → `out`=1 one cycle after the final valid edge; no pulse during the gap.
- Stream 1,1,0, then `arstn`=0 for one edge, then 1 → no pulse; `out`=0 and `match_cnt`=0 after the reset edge.
- `pat_load`=1 with `pat_in`=4'b1011, then stream 1,0,1,1,0,1,1 with overlap=1 → pulses after bits 4 and 7; `match_cnt`=2.
- `CNT_W`=2, pattern 1111, overlap=1, seven 1s → `out` high for 4 consecutive cycles; `match_cnt` saturates at 3. Then `cnt_clr` asserted together with an eighth 1 → `match_cnt`=0 and `out`=1.
